mul_acc_cell: RTL and testbench
===============================

Name: mul_acc_cell

Overview:
- Parametrised successor to the fixed 32x32, two-register multiplier cell in the CPU execute/memory/writeback path.
- Multiplies two operands, each with its own signed/unsigned flag, through a configurable number of enable-gated pipeline stages.
- Adds an optional multiply-accumulate mode with a guard-bit accumulator, a sticky overflow flag and a travelling valid bit.
- Sits between the ALU operand muxes and the writeback/custom-instruction result mux.

Parameters:
- WIDTH_A, 32, width of operand A.
- WIDTH_B, 32, width of operand B.
- ACC_GUARD, 8, extra accumulator MSBs; RW = WIDTH_A+WIDTH_B+ACC_GUARD.
- PIPE_STAGES, 2, number of register stages (legal range 2..4).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- stage_en  in  PIPE_STAGES  per-stage enable; bit k gates stage k registers.
- in_valid  in  1  operands present this cycle.
- src_a  in  WIDTH_A  operand A.
- src_b  in  WIDTH_B  operand B.
- src_a_signed  in  1  1 = A is two's complement.
- src_b_signed  in  1  1 = B is two's complement.
- mac_mode  in  1  0 = plain multiply; 1 = accumulate.
- acc_clr  in  1  synchronous accumulator and overflow clear, sampled at the final stage.
- result  out  RW  product or accumulator value.
- result_valid  out  1  result updated by a valid op this cycle.
- acc_ovf  out  1  sticky signed overflow of the accumulator.

Behaviour:
- Reset: every stage register, valid bit, result, result_valid and acc_ovf go to 0 immediately, without waiting for a clock. This applies mid-operation; in-flight ops are discarded.
- Stage 0: when stage_en[0]=1, captures src_a, src_b, both signed flags, mac_mode and in_valid.
- Product: each operand is extended by one bit, sign-extended when its flag is 1 and zero-extended otherwise. The two extended values are multiplied as signed numbers and the low WIDTH_A+WIDTH_B bits are kept.
- The product is then extended to RW bits. Sign extension applies if either flag is 1; otherwise zero extension.
- Stages 1..PIPE_STAGES-2: product and control pipeline registers. Stage k loads from stage k-1 when stage_en[k]=1; the valid bit is copied, so bubbles propagate.
- Final stage (PIPE_STAGES-1): loads only when stage_en[last]=1.
  - Incoming valid=1, mac_mode=0: result <= product.
  - Incoming valid=1, mac_mode=1: result <= result + product, as RW-bit two's complement arithmetic. acc_ovf is set if the signed addition overflows.
  - Incoming valid=0: result holds its value.
  - result_valid <= incoming valid, updated whenever stage_en[last]=1.
  - acc_clr=1 together with a valid MAC op: the accumulator is cleared first, so result <= product and acc_ovf <= 0.
  - acc_clr=1 with no valid MAC op: result <= 0 and acc_ovf <= 0. In multiply mode, acc_clr does not override the product load but still clears acc_ovf.
- Disabled stages: a stage with its enable low holds everything, including its valid bit, so data is never lost while a later stage stalls.
- Latency: with all enables high, a valid op presented in cycle t appears on result in cycle t+PIPE_STAGES.
- No internal back-pressure: the pipeline controller drives stage_en so that a stalled stage is never overwritten.
- Default parameters with both flags and mac_mode tied, mac_mode=0: behaviour is bit-identical to the earlier cell (lower 64 bits of result; stage_en = {A_en, M_en}).

Decomposition:
- Shared package holds:
  - the RW computation function;
  - the operand-extend and product-extend functions;
  - legal PIPE_STAGES bounds and a range check asserted at elaboration.
- One sub-module, mul_acc_core: the signed (WIDTH_A+1)x(WIDTH_B+1) multiply, registered or combinational by parameter.
- The top level keeps staging, valid tracking and the accumulator.

Test Plan:
1. Defaults; A=-3 (0xFFFFFFFD) signed, B=5 signed, multiply, all enables high → 2 cycles later result = 72'hFF_FFFF_FFFF_FFFF_FFF1 (-15), result_valid=1 for one cycle.
2. A=B=0xFFFFFFFF, both unsigned → result = 0x00_FFFFFFFE_00000001; the same operands with A signed → -0xFFFFFFFF, i.e. 0xFF_FFFFFFFF_00000001.
3. MAC, PIPE_STAGES=3: acc_clr on the first op, then 2*3, 4*5, -1*7 (signed) on consecutive cycles → result sequence 6, 26, 19; acc_ovf=0.
4. WIDTH_A=WIDTH_B=4, ACC_GUARD=1 (RW=9): unsigned 15*15 MAC twice → 225, then -62 (0x1C2) with acc_ovf=1. A following acc_clr with no valid op → result=0, acc_ovf=0.
5. stage_en[last]=0 for 3 cycles while a valid op sits in stage 0 and stage_en[0] is held low → result and result_valid hold; after release the op emerges once, not duplicated or dropped.
6. Assert reset_n low mid-MAC with two ops in flight → all outputs 0 immediately; after release, the first new op yields its plain product with no stale accumulation.

Source files
------------

// File: rtl/mul_acc_cell_pkg.sv
// mul_acc_cell_pkg: shared widths, extension helpers and pipeline-depth bounds
package mul_acc_cell_pkg;
  localparam int PIPE_MIN = 2;
  localparam int PIPE_MAX = 4;
  localparam int MAX_W = 256;

  function automatic int calc_rw(input int wa, input int wb, input int guard);
    return wa + wb + guard;
  endfunction

  function automatic bit pipe_ok(input int n);
    return n >= PIPE_MIN && n <= PIPE_MAX;
  endfunction

  // sign- or zero-extend the low w bits of v across all MAX_W bits
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v, input int w, input logic sgn);
    logic [MAX_W-1:0] hi, t;
    hi = {MAX_W{1'b1}} << w;
    t = v >> (w - 1);
    return (sgn && t[0]) ? (v | hi) : (v & ~hi);
  endfunction

  function automatic logic [MAX_W-1:0] ext_op(input logic [MAX_W-1:0] v, input int w, input logic sgn);
    return extend(v, w, sgn);
  endfunction

  // sx is the OR of both operand signed flags
  function automatic logic [MAX_W-1:0] ext_prod(input logic [MAX_W-1:0] v, input int w, input logic sx);
    return extend(v, w, sx);
  endfunction
endpackage

// File: rtl/mul_acc_core.sv
// mul_acc_core: signed (WA+1)x(WB+1) multiply keeping the low WA+WB bits, optionally registered
module mul_acc_core #(
  parameter int WA = 32,
  parameter int WB = 32,
  parameter bit REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic signed [WA:0] a,
  input  logic signed [WB:0] b,
  output logic [WA+WB-1:0]  p
);
  localparam int PW = WA + WB;
  logic [PW-1:0] prod;
  // the low PW product bits only depend on the low PW bits of each sign-extended operand
  assign prod = PW'(a) * PW'(b);
  if (REG) begin : g_reg
    // product register doubling as pipeline stage 1
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) p <= '0;
      else if (en) p <= prod;
  end else begin : g_comb
    logic unused;
    assign unused = &{1'b0, clk, reset_n, en};
    assign p = prod;
  end
endmodule

// File: rtl/mul_acc_cell.sv
// mul_acc_cell: multiply / multiply-accumulate cell with an enable-gated 2..4 stage pipeline
module mul_acc_cell
  import mul_acc_cell_pkg::*;
#(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 32,
  parameter int ACC_GUARD = 8,
  parameter int PIPE_STAGES = 2,
  localparam int RW = calc_rw(WIDTH_A, WIDTH_B, ACC_GUARD)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PIPE_STAGES-1:0] stage_en,
  input  logic                   in_valid,
  input  logic [WIDTH_A-1:0]     src_a,
  input  logic [WIDTH_B-1:0]     src_b,
  input  logic                   src_a_signed,
  input  logic                   src_b_signed,
  input  logic                   mac_mode,
  input  logic                   acc_clr,
  output logic [RW-1:0]          result,
  output logic                   result_valid,
  output logic                   acc_ovf
);
  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int L = PIPE_STAGES - 1;

  if (!pipe_ok(PIPE_STAGES)) begin : g_bad_depth
    $error("mul_acc_cell: PIPE_STAGES must lie in [%0d,%0d]", PIPE_MIN, PIPE_MAX);
  end
  if (RW > MAX_W) begin : g_bad_width
    $error("mul_acc_cell: result width exceeds the extension helpers");
  end

  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic sa_q, sb_q;
  logic [L-1:0] v_q, m_q, x_q;
  logic signed [WIDTH_A:0] a_x;
  logic signed [WIDTH_B:0] b_x;
  logic [PW-1:0] c_p, fin_p;
  logic [RW-1:0] prod, sum;
  logic ovf;

  // stage 0 captures operands; stages 1..L-1 carry valid, mode and extension flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      v_q <= '0;
      m_q <= '0;
      x_q <= '0;
    end else begin
      if (stage_en[0]) begin
        a_q <= src_a;
        b_q <= src_b;
        sa_q <= src_a_signed;
        sb_q <= src_b_signed;
        v_q[0] <= in_valid;
        m_q[0] <= mac_mode;
        x_q[0] <= src_a_signed | src_b_signed;
      end
      for (int k = 1; k < L; k++)
        if (stage_en[k]) begin
          v_q[k] <= v_q[k-1];
          m_q[k] <= m_q[k-1];
          x_q[k] <= x_q[k-1];
        end
    end

  assign a_x = (WIDTH_A+1)'(ext_op(MAX_W'(a_q), WIDTH_A, sa_q));
  assign b_x = (WIDTH_B+1)'(ext_op(MAX_W'(b_q), WIDTH_B, sb_q));

  mul_acc_core #(.WA(WIDTH_A), .WB(WIDTH_B), .REG(PIPE_STAGES > 2)) u_core (
    .clk(clk),
    .reset_n(reset_n),
    .en(stage_en[1]),
    .a(a_x),
    .b(b_x),
    .p(c_p)
  );

  if (PIPE_STAGES == 4) begin : g_mid
    logic [PW-1:0] p2;
    // stage 2 product register for the deepest pipeline
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) p2 <= '0;
      else if (stage_en[2]) p2 <= c_p;
    assign fin_p = p2;
  end else begin : g_nomid
    assign fin_p = c_p;
  end

  assign prod = RW'(ext_prod(MAX_W'(fin_p), PW, x_q[L-1]));
  assign sum = result + prod;
  assign ovf = (result[RW-1] == prod[RW-1]) && (sum[RW-1] != result[RW-1]);

  // final stage: product load, accumulate, clear and sticky overflow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      result <= '0;
      result_valid <= 1'b0;
      acc_ovf <= 1'b0;
    end else if (stage_en[L]) begin
      result_valid <= v_q[L-1];
      if (v_q[L-1]) result <= (m_q[L-1] && !acc_clr) ? sum : prod;
      else if (acc_clr) result <= '0;
      if (acc_clr) acc_ovf <= 1'b0;
      else if (v_q[L-1] && m_q[L-1] && ovf) acc_ovf <= 1'b1;
    end
endmodule

// File: tb/tb_mul_acc_cell.sv
// tb_mul_acc_cell: vectors, corner sequences and a random run against an arithmetic model
module tb_mul_acc_cell;
  localparam int NR = 400;

  typedef struct {
    logic [31:0] a, b;
    logic sa, sb;
    logic [71:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic sa, sb, m, v;
  } op_t;

  logic clk, reset_n, in_valid, sa, sb, mac_mode, acc_clr;
  logic [3:0] en;
  logic [31:0] src_a, src_b;
  logic [71:0] r0, r3;
  logic [8:0] r4;
  logic rv0, rv3, rv4, ov0, ov3, ov4;

  int pass_cnt = 0;
  int total_cnt = 0;

  vec_t vt[7];
  op_t hist[NR];
  logic [127:0] mr[3];
  logic mv[3], mo[3];
  int pd[3] = '{2, 3, 4};
  int wd[3] = '{32, 32, 4};
  int rwd[3] = '{72, 72, 9};

  mul_acc_cell u_d0 (
    .clk(clk), .reset_n(reset_n), .stage_en(en[1:0]), .in_valid(in_valid),
    .src_a(src_a), .src_b(src_b), .src_a_signed(sa), .src_b_signed(sb),
    .mac_mode(mac_mode), .acc_clr(acc_clr), .result(r0), .result_valid(rv0), .acc_ovf(ov0)
  );

  mul_acc_cell #(.PIPE_STAGES(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .stage_en(en[2:0]), .in_valid(in_valid),
    .src_a(src_a), .src_b(src_b), .src_a_signed(sa), .src_b_signed(sb),
    .mac_mode(mac_mode), .acc_clr(acc_clr), .result(r3), .result_valid(rv3), .acc_ovf(ov3)
  );

  mul_acc_cell #(.WIDTH_A(4), .WIDTH_B(4), .ACC_GUARD(1), .PIPE_STAGES(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .stage_en(en), .in_valid(in_valid),
    .src_a(src_a[3:0]), .src_b(src_b[3:0]), .src_a_signed(sa), .src_b_signed(sb),
    .mac_mode(mac_mode), .acc_clr(acc_clr), .result(r4), .result_valid(rv4), .acc_ovf(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", n, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sa_i, input logic sb_i, input logic m, input logic clr);
    in_valid = v;
    src_a = a;
    src_b = b;
    sa = sa_i;
    sb = sb_i;
    mac_mode = m;
    acc_clr = clr;
  endtask

  // two's complement value of the low w bits of raw, as a 128-bit number
  function automatic logic [127:0] to_val(input logic [127:0] raw, input int w, input logic sgn);
    logic [127:0] m, t;
    m = ~({128{1'b1}} << w);
    t = raw >> (w - 1);
    return (sgn && t[0]) ? (raw & m) - (128'd1 << w) : (raw & m);
  endfunction

  // operand values multiplied exactly, low 2w bits reinterpreted, then wrapped to rwv bits
  function automatic logic [127:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa_i, input logic sb_i, input int w, input int rwv);
    logic [127:0] p;
    p = to_val(128'(a), w, sa_i) * to_val(128'(b), w, sb_i);
    return to_val(p, 2 * w, sa_i | sb_i) & ~({128{1'b1}} << rwv);
  endfunction

  task automatic model_step(input int d, input op_t o, input logic clr);
    logic [127:0] p;
    logic signed [127:0] s, lim;
    p = ref_prod(o.a, o.b, o.sa, o.sb, wd[d], rwd[d]);
    mv[d] = o.v;
    if (o.v && o.m && !clr) begin
      s = to_val(mr[d], rwd[d], 1'b1) + to_val(p, rwd[d], 1'b1);
      lim = (128'sd1 <<< (rwd[d] - 1)) - 1;
      if (s > lim || s < -lim - 1) mo[d] = 1'b1;
      mr[d] = s & ~({128{1'b1}} << rwd[d]);
    end else if (o.v) begin
      mr[d] = p;
      if (clr) mo[d] = 1'b0;
    end else if (clr) begin
      mr[d] = '0;
      mo[d] = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 20);
      1: return 32'hFFFFFFFF - $urandom_range(0, 20);
      2: return 32'h80000000 ^ $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    op_t bub;
    bub = '{default: '0};
    vt[0] = '{32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 72'hFF_FFFF_FFFF_FFFF_FFF1};
    vt[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 72'h00_FFFF_FFFE_0000_0001};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 72'hFF_FFFF_FFFF_0000_0001};
    vt[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 72'h00_0000_0000_0000_0001};
    vt[4] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 72'h00_4000_0000_0000_0000};
    vt[5] = '{32'h80000000, 32'd2, 1'b0, 1'b1, 72'h00_0000_0001_0000_0000};
    vt[6] = '{32'd7, 32'hFFFFFFFF, 1'b1, 1'b0, 72'h00_0000_0006_FFFF_FFF9};

    reset_n = 1'b0;
    en = 4'hF;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset r0", r0, 0);
    chk("reset rv0", rv0, 0);
    chk("reset ov0", ov0, 0);
    chk("reset r3", r3, 0);
    chk("reset r4", r4, 0);
    step();
    step();
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(1, vt[i].a, vt[i].b, vt[i].sa, vt[i].sb, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      chk($sformatf("vec%0d result", i), r0, vt[i].exp);
      chk($sformatf("vec%0d valid", i), rv0, 1);
      step();
      chk($sformatf("vec%0d valid_drop", i), rv0, 0);
    end

    drive(1, 2, 3, 1, 1, 1, 0);
    step();
    drive(1, 4, 5, 1, 1, 1, 0);
    step();
    drive(1, 32'hFFFFFFFF, 7, 1, 1, 1, 1);
    step();
    chk("mac3 first", r3, 6);
    chk("mac3 first valid", rv3, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("mac3 second", r3, 26);
    step();
    chk("mac3 third", r3, 19);
    chk("mac3 ovf", ov3, 0);

    drive(1, 15, 15, 0, 0, 1, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk("mac4 first", r4, 9'h0E1);
    chk("mac4 first ovf", ov4, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("mac4 second", r4, 9'h1C2);
    chk("mac4 second ovf", ov4, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk("mac4 clr result", r4, 0);
    chk("mac4 clr ovf", ov4, 0);
    chk("mac4 clr valid", rv4, 0);

    drive(1, 3, 3, 0, 0, 0, 0);
    step();
    drive(1, 6, 7, 0, 0, 0, 0);
    step();
    chk("stall pre result", r0, 9);
    chk("stall pre valid", rv0, 1);
    en = 4'h0;
    drive(1, 100, 100, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d hold result", i), r0, 9);
      chk($sformatf("stall%0d hold valid", i), rv0, 1);
    end
    en = 4'hF;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("stall release result", r0, 42);
    chk("stall release valid", rv0, 1);
    step();
    chk("stall once result", r0, 42);
    chk("stall once valid", rv0, 0);

    drive(1, 5, 5, 1, 1, 1, 0);
    step();
    drive(1, 2, 2, 1, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    chk("async r3", r3, 0);
    chk("async rv3", rv3, 0);
    chk("async ov3", ov3, 0);
    chk("async r0", r0, 0);
    chk("async r4", r4, 0);
    #1;
    reset_n = 1'b1;
    drive(1, 3, 4, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("post reset no stale", rv3, 0);
    step();
    chk("post reset result", r3, 12);
    chk("post reset valid", rv3, 1);
    chk("post reset ovf", ov3, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mr[d] = '0;
      mv[d] = 1'b0;
      mo[d] = 1'b0;
    end
    for (int c = 0; c < NR; c++) begin
      op_t o;
      logic clr;
      o.a = rnd_op();
      o.b = rnd_op();
      o.sa = 1'($urandom_range(0, 1));
      o.sb = 1'($urandom_range(0, 1));
      o.m = 1'($urandom_range(0, 1));
      o.v = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 9) == 0;
      hist[c] = o;
      drive(o.v, o.a, o.b, o.sa, o.sb, o.m, clr);
      for (int d = 0; d < 3; d++)
        model_step(d, (c >= pd[d] - 1) ? hist[c - pd[d] + 1] : bub, clr);
      step();
      for (int d = 0; d < 3; d++) begin
        logic [127:0] ar;
        logic av, ao;
        ar = d == 0 ? 128'(r0) : d == 1 ? 128'(r3) : 128'(r4);
        av = d == 0 ? rv0 : d == 1 ? rv3 : rv4;
        ao = d == 0 ? ov0 : d == 1 ? ov3 : ov4;
        chk($sformatf("rnd dut%0d cyc%0d result", d, c), ar, mr[d]);
        chk($sformatf("rnd dut%0d cyc%0d valid", d, c), av, mv[d]);
        chk($sformatf("rnd dut%0d cyc%0d ovf", d, c), ao, mo[d]);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
